// File: rtl/sim_debug_port_pkg.sv
// Shared definitions for the simulation/debug port: register map, STATUS layout, timeout exit code.
package sim_debug_port_pkg;

  typedef enum logic [1:0] {
    REG_CONSOLE = 2'd0,
    REG_EXIT    = 2'd1,
    REG_COUNT   = 2'd2
  } reg_off_e;

  localparam int STAT_FULL     = 0;
  localparam int STAT_OVERFLOW = 1;
  localparam int STAT_DONE     = 2;
  localparam int STAT_TIMEOUT  = 3;

  localparam logic [7:0] EXIT_CODE_TIMEOUT = 8'hFF;

  function automatic logic [7:0] pack_status(input logic full, input logic overflow,
                                             input logic done, input logic timeout);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_FULL]     = full;
    s[STAT_OVERFLOW] = overflow;
    s[STAT_DONE]     = done;
    s[STAT_TIMEOUT]  = timeout;
    return s;
  endfunction

endpackage

// File: rtl/sim_debug_port_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted only if a pop frees a slot
// in the same cycle, otherwise it is dropped and flagged on o_drop. Output reads 0 while empty.
module sim_debug_port_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned W     = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic          o_drop
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && !w_push;
  assign o_count = r_count;
  assign o_dat   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/sim_debug_port.sv
// Memory-mapped console/exit-code port for simulation; optional watchdog enabled by
// SIM_DEBUG_PORT_WATCHDOG_EN forces DONE with exit code 8'hFF after TIMEOUT_CYCLES.
module sim_debug_port
  import sim_debug_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'hFF00,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_bus_addr,
  input  logic [7:0]  i_bus_data_in,
  input  logic        i_bus_we,
  input  logic        i_bus_re,
  output logic [7:0]  o_bus_data_out,
  output logic        o_bus_data_oe,
  output logic [7:0]  o_con_data,
  output logic        o_con_valid,
  input  logic        i_con_ready,
  output logic        o_done,
  output logic [7:0]  o_exit_code,
  output logic        o_timeout
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   w_off;
  logic          w_sel;
  reg_off_e      w_reg;
  logic          w_wr_console;
  logic          w_wr_exit;
  logic          w_exit_take;
  logic          w_wd_expire;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic [CW-1:0] w_count;
  logic          r_overflow;
  logic          r_done;
  logic [7:0]    r_exit_code;

  // Subtraction keeps the decode correct for any BASE_ADDR alignment.
  assign w_off        = i_bus_addr - BASE_ADDR;
  assign w_sel        = (w_off < 16'd3);
  assign w_reg        = reg_off_e'(w_off[1:0]);
  assign w_wr_console = i_bus_we && w_sel && (w_reg == REG_CONSOLE);
  assign w_wr_exit    = i_bus_we && w_sel && (w_reg == REG_EXIT);
  assign w_exit_take  = w_wr_exit && !r_done;

  sim_debug_port_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_wr_console),
    .i_dat   (i_bus_data_in),
    .i_pop   (i_con_ready),
    .o_dat   (o_con_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );

  assign o_con_valid = !w_empty;

`ifdef SIM_DEBUG_PORT_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_timeout;

  assign w_wd_expire = !r_done && (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign o_timeout   = r_timeout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!r_done) r_wd_cnt <= r_wd_cnt + 32'd1;
      // A real EXIT write in the expiry cycle takes precedence over the timeout.
      if (w_wd_expire && !w_exit_take) r_timeout <= 1'b1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
      r_exit_code <= 8'h00;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_exit_take) begin
        r_done      <= 1'b1;
        r_exit_code <= i_bus_data_in;
      end else if (w_wd_expire) begin
        r_done      <= 1'b1;
        r_exit_code <= EXIT_CODE_TIMEOUT;
      end
    end
  end

  assign o_done        = r_done;
  assign o_exit_code   = r_exit_code;
  assign o_bus_data_oe = i_bus_re && w_sel;

  always_comb begin
    o_bus_data_out = 8'h00;
    if (i_bus_re && w_sel) begin
      case (w_reg)
        REG_CONSOLE: o_bus_data_out = pack_status(w_full, r_overflow, r_done, o_timeout);
        REG_EXIT:    o_bus_data_out = r_exit_code;
        REG_COUNT:   o_bus_data_out = 8'(w_count);
        default:     o_bus_data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_debug_port.sv
// Bench for sim_debug_port: directed and random bus traffic checked against a queue-based model.
module tb_sim_debug_port;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 8;
  localparam int          TO    = 16;
`ifdef SIM_DEBUG_PORT_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_in;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_data_out;
  logic        bus_data_oe;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        done;
  logic [7:0]  exit_code;
  logic        timeout;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_done;
  bit         m_to;
  logic [7:0] m_code;
  int         m_cyc;

  always #5 clk = ~clk;

  sim_debug_port #(
    .BASE_ADDR      (BASE),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_bus_addr     (bus_addr),
    .i_bus_data_in  (bus_data_in),
    .i_bus_we       (bus_we),
    .i_bus_re       (bus_re),
    .o_bus_data_out (bus_data_out),
    .o_bus_data_oe  (bus_data_oe),
    .o_con_data     (con_data),
    .o_con_valid    (con_valid),
    .i_con_ready    (con_ready),
    .o_done         (done),
    .o_exit_code    (exit_code),
    .o_timeout      (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_done = 1'b0;
    m_to   = 1'b0;
    m_code = 8'h00;
    m_cyc  = 0;
  endtask

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    case (off)
      16'd0:   return {4'b0000, m_to, m_done, m_ovf, (mq.size() == DEPTH)};
      16'd1:   return m_code;
      16'd2:   return 8'(mq.size());
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, 32'(con_valid), 32'(mq.size() != 0));
    chk({tag, ".data"},  32'(con_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, ".done"},  32'(done),      32'(m_done));
    chk({tag, ".code"},  32'(exit_code), 32'(m_code));
    chk({tag, ".tout"},  32'(timeout),   32'(m_to));
  endtask

  // One clock cycle with the given bus/sink inputs; model advances on the same edge.
  task automatic step(input logic we, input logic [15:0] a, input logic [7:0] d,
                      input logic rdy, input string tag);
    bit was_done;
    bit pop;
    bus_we = we; bus_addr = a; bus_data_in = d; con_ready = rdy;
    @(posedge clk);
    was_done = m_done;
    pop = rdy && (mq.size() != 0);
    if (pop) void'(mq.pop_front());
    if (we && a == BASE) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
    if (we && a == BASE + 16'd1 && !was_done) begin
      m_done = 1'b1;
      m_code = d;
    end else if (WD && !was_done && m_cyc == TO - 1) begin
      m_done = 1'b1;
      m_to   = 1'b1;
      m_code = 8'hFF;
    end
    if (!was_done) m_cyc++;
    #1;
    bus_we = 1'b0;
    check_out(tag);
  endtask

  task automatic rd(input logic [15:0] a, input string tag);
    bus_re = 1'b1; bus_addr = a;
    #1;
    chk({tag, ".rdata"}, 32'(bus_data_out), 32'(exp_read(a)));
    chk({tag, ".oe"},    32'(bus_data_oe),  32'((a - BASE) < 16'd3));
    bus_re = 1'b0;
  endtask

  // Asserts reset between edges, checks the immediate effect, then releases it.
  task automatic mid_reset(input string tag);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_out(tag);
    chk({tag, ".oe0"},  32'(bus_data_oe),  32'd0);
    chk({tag, ".dout0"}, 32'(bus_data_out), 32'd0);
    rd(BASE, {tag, ".status"});
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] a;
    logic        we;
    logic        rdy;
    int          r;

    rst = 1'b1; bus_addr = 16'h0000; bus_data_in = 8'h00;
    bus_we = 1'b0; bus_re = 1'b0; con_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_out("rst");
    chk("rst.oe", 32'(bus_data_oe), 32'd0);
    rst = 1'b0;
    rd(BASE,          "rst.status");
    rd(BASE + 16'd2,  "rst.count");

    // Two bytes through an always-ready sink
    step(1'b1, BASE, 8'h48, 1'b1, "hi.0");
    step(1'b1, BASE, 8'h69, 1'b1, "hi.1");
    step(1'b0, BASE, 8'h00, 1'b1, "hi.2");
    step(1'b0, BASE, 8'h00, 1'b1, "hi.3");

    // Fill with a stalled sink, overflow on the ninth byte
    for (int i = 0; i < 9; i++) step(1'b1, BASE, 8'($urandom), 1'b0, "fill");
    rd(BASE + 16'd2, "fill.count");
    rd(BASE,         "fill.status");
    chk("fill.status_const", 32'(bus_data_out), 32'h03);

    // Push and pop together while full
    for (int i = 0; i < 3; i++) step(1'b1, BASE, 8'($urandom), 1'b1, "fullpp");
    rd(BASE + 16'd2, "fullpp.count");
    rd(BASE,         "fullpp.status");

    // Count register writes are ignored; stalled sink holds its data
    step(1'b1, BASE + 16'd2, 8'hAA, 1'b0, "cntwr");
    rd(BASE + 16'd2, "cntwr.count");
    for (int i = 0; i < 10; i++) step(1'b0, BASE, 8'h00, 1'b1, "drain");
    rd(BASE + 16'd3, "unsel.ff03");
    rd(16'h0000,     "unsel.0000");

    // Reset mid-run discards FIFO contents
    for (int i = 0; i < 3; i++) step(1'b1, BASE, 8'($urandom), 1'b0, "pre_rst");
    mid_reset("midrst");
    step(1'b0, BASE, 8'h00, 1'b1, "post_rst");

    // Exit code: first write wins, console keeps working afterwards
    step(1'b1, BASE + 16'd1, 8'h00, 1'b0, "exit.0");
    step(1'b1, BASE + 16'd1, 8'h05, 1'b0, "exit.1");
    rd(BASE + 16'd1, "exit.code");
    rd(BASE,         "exit.status");
    step(1'b1, BASE, 8'h5A, 1'b0, "exit.push");
    step(1'b0, BASE, 8'h00, 1'b1, "exit.drain");

    // Idle run past the watchdog limit
    mid_reset("wdrst");
    for (int i = 0; i < TO + 4; i++) step(1'b0, BASE, 8'h00, 1'b0, "idle");
    rd(BASE,         "idle.status");
    rd(BASE + 16'd1, "idle.code");

    // Random traffic, alternating sink pressure
    mid_reset("rndrst");
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      we = (r < 6);
      r  = $urandom_range(0, 9);
      if (r < 6)       a = BASE;
      else if (r == 6) a = ($urandom_range(0, 19) == 0) ? BASE + 16'd1 : BASE;
      else if (r == 7) a = BASE + 16'd2;
      else if (r == 8) a = BASE + 16'd3;
      else             a = 16'($urandom);
      b   = 8'($urandom);
      rdy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(we, a, b, rdy, "rnd");
      r = $urandom_range(0, 3);
      rd(BASE + 16'(r), "rnd.rd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
